// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray counter run/pause/step controller:
// state encodings and the command arbitration order.
package gray_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t RUN   = 2'b01;
  localparam state_t PAUSE = 2'b10;
  localparam state_t DONE  = 2'b11;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_STEP,
    CMD_START,
    CMD_STOP,
    CMD_CLEAR
  } cmd_t;

  // Only the highest-priority command of a cycle is acted on; the rest are dropped.
  function automatic cmd_t pick_cmd(input logic clear, input logic stop,
                                    input logic start, input logic step);
    if (clear)      return CMD_CLEAR;
    else if (stop)  return CMD_STOP;
    else if (start) return CMD_START;
    else if (step)  return CMD_STEP;
    else            return CMD_NONE;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button path: 2-FF synchroniser, debounce counter, registered
// rising-edge pulse on the debounced level.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE-th consecutive cycle of disagreement.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync_q[1];
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_q      <= {sync_q[0], btn_raw};
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// Run/pause/single-step controller gating the 1 Hz tick into the Gray
// counter enable, with a tick counter and programmable auto-stop limit.
module gray_run_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1000000,
  parameter int unsigned TICK_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_stop,
  input  logic              btn_step,
  input  logic              btn_clear,
  input  logic              pulse_in,
  input  logic [TICK_W-1:0] stop_count,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic [1:0]        state,
  output logic [TICK_W-1:0] ticks,
  output logic              done
);

  logic [3:0] btn_raw;
  logic [3:0] btn_rise;
  logic [3:0] btn_level_unused;

  assign btn_raw = {btn_clear, btn_step, btn_stop, btn_start};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[g]),
      .btn_level (btn_level_unused[g]),
      .btn_rise  (btn_rise[g])
    );
  end

  cmd_t              cmd;
  state_t            state_q, state_d;
  logic [TICK_W-1:0] ticks_q, ticks_d, ticks_inc;
  logic              en_q, en_d;
  logic              clr_q, clr_d;
  logic              issue;

  assign cmd       = pick_cmd(btn_rise[3], btn_rise[1], btn_rise[0], btn_rise[2]);
  assign ticks_inc = ticks_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd == CMD_START)     state_d = RUN;
        else if (cmd == CMD_STEP) issue   = 1'b1;
      end
      RUN: begin
        if (cmd == CMD_STOP) state_d = PAUSE;
        else if (pulse_in)   issue   = 1'b1;
      end
      PAUSE: begin
        if (cmd == CMD_START)     state_d = RUN;
        else if (cmd == CMD_STEP) issue   = 1'b1;
      end
      DONE:    ;
      default: ;
    endcase
    if (issue) begin
      en_d    = 1'b1;
      ticks_d = ticks_inc;
      if (stop_count != '0 && ticks_inc >= stop_count) state_d = DONE;
    end
    // Clear overrides anything decided above, including a tick in the same cycle.
    if (cmd == CMD_CLEAR) begin
      state_d = IDLE;
      ticks_d = '0;
      en_d    = 1'b0;
      clr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ticks_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ticks_q <= ticks_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign state   = state_q;
  assign ticks   = ticks_q;
  assign done    = (state_q == DONE);

endmodule

// File: doc/gray_run_ctrl.md
# gray_run_ctrl

Run/pause/single-step controller for the Gray LED counter datapath. It sits between the board push-buttons and the counter enable path. It conditions four raw buttons (synchronise, debounce, edge-detect) and sequences the counter through IDLE/RUN/PAUSE/DONE. It gates the 1 Hz tick from the pulse generator into the counter's clock enable, and counts delivered ticks against a programmable stop limit.

## Interface
Parameters:
- `DEBOUNCE`, default 1000000: cycles a synchronised button must differ from its debounced level before the level flips (10 ms at a 10 ns clock).
- `TICK_W`, default 16: width of the tick counter and stop limit.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous active-low reset.
- `btn_start`, input, 1: raw button, asynchronous.
- `btn_stop`, input, 1: raw button, asynchronous.
- `btn_step`, input, 1: raw button, asynchronous.
- `btn_clear`, input, 1: raw button, asynchronous.
- `pulse_in`, input, 1: one-cycle tick from the pulse generator.
- `stop_count`, input, TICK_W: auto-stop limit; 0 means free run.
- `cnt_en`, output, 1: registered one-cycle clock enable to the Gray counter.
- `cnt_clr`, output, 1: registered one-cycle synchronous clear to the Gray counter.
- `state`, output, 2: current state (IDLE=00, RUN=01, PAUSE=10, DONE=11).
- `ticks`, output, TICK_W: number of `cnt_en` pulses issued since the last clear.
- `done`, output, 1: high while in DONE.

## Operation
- Each button path: 2-FF synchroniser, then debounce counter, then rising-edge detect. The result is a one-cycle command (`c_start`, `c_stop`, `c_step`, `c_clear`).
- Debounce counter resets whenever the synchronised input equals the debounced level. On reaching `DEBOUNCE` the debounced level takes the synchronised value.
- Command priority when several fire in one cycle: clear > stop > start > step.
- IDLE:
  - `c_start` → RUN.
  - `c_step` → stay in IDLE, issue one `cnt_en`.
- RUN:
  - Each `pulse_in` → `cnt_en`.
  - `c_stop` → PAUSE.
  - `c_step` is ignored.
- PAUSE:
  - `c_start` → RUN.
  - `c_step` → one `cnt_en`.
  - `pulse_in` is ignored.
- DONE:
  - Only `c_clear` has effect.
  - `pulse_in` produces no `cnt_en`.
- `c_clear` in any state:
  - state → IDLE.
  - `ticks` → 0.
  - `cnt_clr` = 1 for one cycle.
  - no `cnt_en` in that cycle.
- `ticks` increments on every issued `cnt_en`.
  - If `stop_count` ≠ 0 and the incremented value ≥ `stop_count` → DONE.
  - The comparison uses the live `stop_count`, so lowering the limit below the current `ticks` stops the counter at the next `cnt_en`.
- With `stop_count` = 0, `ticks` wraps from 2^TICK_W−1 to 0 and the state stays RUN.
- In the same cycle as `pulse_in` in RUN:
  - `c_stop`: stop wins, no `cnt_en`.
  - `c_clear`: clear wins, no `cnt_en`.

## Timing
- Reset values: `cnt_en`=0, `cnt_clr`=0, `state`=IDLE, `ticks`=0, `done`=0. All debounced levels and debounce counters are 0.
- Reset asserted mid-run returns every output to its reset value immediately (asynchronous). No `cnt_clr` is issued; the counter has its own reset.
- Button latency, for a raw level rising at cycle t and held:
  - synchronised at t+2;
  - debounced level high at t+2+DEBOUNCE;
  - command pulse at t+3+DEBOUNCE;
  - `state`, `cnt_en` and `cnt_clr` update at t+4+DEBOUNCE.
- Tick latency: `pulse_in` at cycle k in RUN → `cnt_en` at k+1, and `ticks` and `state` (DONE if the limit is hit) update at k+1.
- `done` is combinationally equal to (`state` == DONE).
- A button held high produces exactly one command. A release shorter than `DEBOUNCE` cycles produces no second command.

## Structure
- Shared package `gray_ctrl_pkg` holds:
  - the state typedef/localparams IDLE/RUN/PAUSE/DONE with the 2-bit encodings above;
  - the command priority order.
- Sub-module `btn_conditioner`, parameterised by `DEBOUNCE`:
  - ports `clk`, `rst`, `btn_raw`, `btn_level`, `btn_rise`;
  - instantiated four times.
- The top level holds the FSM, tick counter, limit compare and output registers.

## Test plan
All scenarios use `DEBOUNCE`=4 and `TICK_W`=8.
1. **Reset and start.** Release reset, hold `btn_start` from cycle 10 → `state`=01 at cycle 18. Four `pulse_in` pulses → four `cnt_en` pulses, each one cycle after its `pulse_in`; `ticks`=4.
2. **Bounce.** `btn_stop` toggles every 2 cycles for 20 cycles, then stays high → exactly one stop command; `state`=10; subsequent `pulse_in` gives no `cnt_en`.
3. **Step.** In PAUSE, press `btn_step` three times → three `cnt_en` pulses, `ticks` increments by 3, `state` stays 10. Step while in RUN → no extra `cnt_en`.
4. **Auto-stop.** `stop_count`=5, start, apply 7 `pulse_in` → `cnt_en` count is 5, `state`=11, `done`=1. Then `btn_start` → no change; `btn_clear` → `cnt_clr` for one cycle, `ticks`=0, `state`=00.
5. **Simultaneous events.** Stop command and `pulse_in` in the same cycle → no `cnt_en`, `state`=10. Start and clear commands in the same cycle → `state`=00, `cnt_clr`=1.
6. **Wrap and mid-run reset.** `stop_count`=0, 256 ticks in RUN → `ticks` wraps to 0 and `state` stays 01. Assert `rst` low mid-run → all outputs at reset values within the same cycle.
